// File: rtl/placar_bcd_acumulador_pkg.sv
// Shared scoreboard definitions: accumulator FSM states, BCD limits and step direction.
// The display packer and the other team's accumulator import this package too.
package placar_pkg;

    typedef enum logic {
        OCIOSO = 1'b0,
        PASSO  = 1'b1
    } estado_t;

    localparam logic [3:0] BCD_MAX       = 4'd9;
    localparam logic       DIR_SOMA      = 1'b0;
    localparam logic       DIR_SUB       = 1'b1;
    localparam int         LIMITE_PADRAO = 99;

endpackage

// File: rtl/placar_bcd_acumulador_if.sv
// Point-request handshake plus the registered score outputs of one team's accumulator.
interface placar_bcd_acumulador_if;

    logic       pts_valid;
    logic       pts_ready;
    logic [1:0] pts_val;
    logic       pts_sub;
    logic       limpar;
    logic [3:0] unidade;
    logic [3:0] dezena;
    logic       saturou;
    logic       ocupado;

    modport master (
        output pts_valid, pts_val, pts_sub, limpar,
        input  pts_ready, unidade, dezena, saturou, ocupado
    );

    modport slave (
        input  pts_valid, pts_val, pts_sub, limpar,
        output pts_ready, unidade, dezena, saturou, ocupado
    );

endinterface

// File: rtl/placar_bcd_acumulador_bcd_passo.sv
// One BCD digit stepped by +1/-1 when i_carry is set; o_carry is the carry or borrow out.
module bcd_passo
    import placar_pkg::*;
(
    input  logic [3:0] i_digito,
    input  logic       i_dir,
    input  logic       i_carry,
    output logic [3:0] o_digito,
    output logic       o_carry
);

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        o_digito = i_digito;
        o_carry  = 1'b0;
        if (i_carry) begin
            if (i_dir == DIR_SOMA) begin
                if (i_digito >= BCD_MAX) begin
                    o_digito = 4'd0;
                    o_carry  = 1'b1;
                end else begin
                    o_digito = i_digito + 4'd1;
                end
            end else begin
                if (i_digito == 4'd0) begin
                    o_digito = BCD_MAX;
                    o_carry  = 1'b1;
                end else begin
                    o_digito = i_digito - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/placar_bcd_acumulador.sv
// Per-team two-digit BCD score: accepts +/-1..3 requests and applies them one point per clock,
// saturating at LIMITE on add and clamping at 00 on subtract.
module placar_bcd_acumulador
    import placar_pkg::*;
#(
    parameter int LIMITE = LIMITE_PADRAO
)
(
    input  logic                    clk,
    input  logic                    rst,
    placar_bcd_acumulador_if.slave  bus
);

    localparam logic [3:0] LIM_DEZ = 4'(LIMITE / 10);
    localparam logic [3:0] LIM_UNI = 4'(LIMITE % 10);

    estado_t    r_estado,  w_prox_estado;
    logic [1:0] r_resta,   w_prox_resta;
    logic       r_dir,     w_prox_dir;
    logic [3:0] r_unidade, w_prox_unidade;
    logic [3:0] r_dezena,  w_prox_dezena;
    logic       r_saturou, w_prox_saturou;

    logic [3:0] w_uni_passo, w_dez_passo;
    logic       w_carry_uni, w_carry_dez;
    logic       w_aceita, w_no_limite, w_satura, w_trava;

    bcd_passo u_passo_uni (
        .i_digito (r_unidade),
        .i_dir    (r_dir),
        .i_carry  (1'b1),
        .o_digito (w_uni_passo),
        .o_carry  (w_carry_uni)
    );

    bcd_passo u_passo_dez (
        .i_digito (r_dezena),
        .i_dir    (r_dir),
        .i_carry  (w_carry_uni),
        .o_digito (w_dez_passo),
        .o_carry  (w_carry_dez)
    );

    assign bus.pts_ready = (r_estado == OCIOSO) && !bus.limpar && !rst;
    assign w_aceita      = bus.pts_valid && bus.pts_ready;
    assign w_no_limite   = (r_dezena == LIM_DEZ) && (r_unidade == LIM_UNI);
    // A carry/borrow out of the tens digit means the step would leave 00..99.
    assign w_satura      = (r_dir == DIR_SOMA) && (w_no_limite || w_carry_dez);
    assign w_trava       = (r_dir == DIR_SUB) && w_carry_dez;

    always_comb begin
        w_prox_estado  = r_estado;
        w_prox_resta   = r_resta;
        w_prox_dir     = r_dir;
        w_prox_unidade = r_unidade;
        w_prox_dezena  = r_dezena;
        w_prox_saturou = r_saturou;

        if (bus.limpar) begin
            w_prox_estado  = OCIOSO;
            w_prox_resta   = 2'd0;
            w_prox_unidade = 4'd0;
            w_prox_dezena  = 4'd0;
            w_prox_saturou = 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (w_aceita && (bus.pts_val != 2'd0)) begin
                        w_prox_resta  = bus.pts_val;
                        w_prox_dir    = bus.pts_sub;
                        w_prox_estado = PASSO;
                    end
                end
                PASSO: begin
                    if (w_satura) begin
                        w_prox_saturou = 1'b1;
                        w_prox_resta   = 2'd0;
                        w_prox_estado  = OCIOSO;
                    end else if (w_trava) begin
                        w_prox_resta   = 2'd0;
                        w_prox_estado  = OCIOSO;
                    end else begin
                        w_prox_unidade = w_uni_passo;
                        w_prox_dezena  = w_dez_passo;
                        w_prox_resta   = r_resta - 2'd1;
                        if (r_resta == 2'd1) begin
                            w_prox_estado = OCIOSO;
                        end
                    end
                end
                default: w_prox_estado = OCIOSO;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado  <= OCIOSO;
            r_resta   <= 2'd0;
            r_dir     <= DIR_SOMA;
            r_unidade <= 4'd0;
            r_dezena  <= 4'd0;
            r_saturou <= 1'b0;
        end else begin
            r_estado  <= w_prox_estado;
            r_resta   <= w_prox_resta;
            r_dir     <= w_prox_dir;
            r_unidade <= w_prox_unidade;
            r_dezena  <= w_prox_dezena;
            r_saturou <= w_prox_saturou;
        end
    end

    assign bus.unidade = r_unidade;
    assign bus.dezena  = r_dezena;
    assign bus.saturou = r_saturou;
    assign bus.ocupado = (r_estado == PASSO);

endmodule

// File: tb/tb_placar_bcd_acumulador.sv
// Scoreboard bench: a decimal score model queues expected per-step and final results per request.
module tb_placar_bcd_acumulador;
    import placar_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    placar_bcd_acumulador_if bus ();

    placar_bcd_acumulador #(.LIMITE(99)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] bcd;
        logic       sat;
        int         busy;
    } final_t;

    logic [7:0] q_passo[$];
    final_t     q_final[$];
    int         m_score;
    logic       m_sat;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic verificar(input string tag, input logic [15:0] obs, input logic [15:0] esp);
        n_cmp++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    function automatic logic [7:0] para_bcd(input int s);
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [7:0] placar();
        return {bus.dezena, bus.unidade};
    endfunction

    task automatic modelo(input int val, input logic sub);
        final_t f;
        int     busy = 0;
        for (int i = 1; i <= val; i++) begin
            busy = i;
            if (!sub && m_score == 99) begin
                m_sat = 1'b1;
                q_passo.push_back(para_bcd(m_score));
                break;
            end
            if (sub && m_score == 0) begin
                q_passo.push_back(para_bcd(m_score));
                break;
            end
            m_score = sub ? m_score - 1 : m_score + 1;
            q_passo.push_back(para_bcd(m_score));
        end
        f.bcd  = para_bcd(m_score);
        f.sat  = m_sat;
        f.busy = busy;
        q_final.push_back(f);
    endtask

    task automatic esperar_pronto(input string tag);
        int n = 0;
        while (!bus.pts_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.pts_ready) verificar({tag, " ready timeout"}, 16'd0, 16'd1);
    endtask

    task automatic enviar(input int val, input logic sub, input string tag);
        final_t     f;
        logic [7:0] e;
        int         n = 0;
        esperar_pronto(tag);
        bus.pts_valid = 1'b1;
        bus.pts_val   = 2'(val);
        bus.pts_sub   = sub;
        modelo(val, sub);
        @(posedge clk);
        @(negedge clk);
        bus.pts_valid = 1'b0;
        while (bus.ocupado && n < 8) begin
            @(negedge clk);
            n++;
            if (q_passo.size() == 0) begin
                verificar({tag, " extra step"}, 16'd1, 16'd0);
            end else begin
                e = q_passo.pop_front();
                verificar({tag, " step"}, 16'(placar()), 16'(e));
            end
        end
        if (q_passo.size() != 0) verificar({tag, " missing steps"}, 16'(q_passo.size()), 16'd0);
        q_passo.delete();
        f = q_final.pop_front();
        verificar({tag, " busy"}, 16'(n), 16'(f.busy));
        verificar({tag, " score"}, 16'(placar()), 16'(f.bcd));
        verificar({tag, " sat"}, 16'(bus.saturou), 16'(f.sat));
        verificar({tag, " ready"}, 16'(bus.pts_ready), 16'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.pts_valid = 1'b0;
        bus.pts_val   = 2'd0;
        bus.pts_sub   = 1'b0;
        bus.limpar    = 1'b0;
        rst           = 1'b1;
        m_score       = 0;
        m_sat         = 1'b0;

        @(negedge clk);
        verificar("rst ready", 16'(bus.pts_ready), 16'd0);
        verificar("rst score", 16'(placar()), 16'h00);
        verificar("rst sat", 16'(bus.saturou), 16'd0);
        verificar("rst busy", 16'(bus.ocupado), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        verificar("post rst ready", 16'(bus.pts_ready), 16'd1);

        enviar(3, DIR_SOMA, "add3");
        enviar(3, DIR_SOMA, "pre");
        enviar(2, DIR_SOMA, "pre");
        enviar(3, DIR_SOMA, "carry");

        while (m_score <= 95) enviar(3, DIR_SOMA, "climb");
        enviar(3, DIR_SOMA, "sat");
        enviar(1, DIR_SOMA, "sat hold");

        while (m_score >= 15) enviar(3, DIR_SUB, "descend");
        enviar(2, DIR_SUB, "to10");
        enviar(2, DIR_SUB, "borrow");
        while (m_score >= 4) enviar(3, DIR_SUB, "descend2");
        enviar(1, DIR_SUB, "to01");
        enviar(3, DIR_SUB, "clamp");
        enviar(1, DIR_SUB, "clamp0");
        enviar(0, DIR_SUB, "noop");

        repeat (6) enviar(3, DIR_SOMA, "build");
        enviar(2, DIR_SOMA, "build");

        // limpar on the second PASSO cycle, with a competing pts_valid
        esperar_pronto("clr");
        bus.pts_valid = 1'b1;
        bus.pts_val   = 2'd3;
        bus.pts_sub   = DIR_SOMA;
        @(posedge clk);
        @(negedge clk);
        bus.pts_valid = 1'b0;
        verificar("clr busy", 16'(bus.ocupado), 16'd1);
        @(negedge clk);
        verificar("clr step1", 16'(placar()), 16'h21);
        bus.limpar    = 1'b1;
        bus.pts_valid = 1'b1;
        verificar("clr ready", 16'(bus.pts_ready), 16'd0);
        @(negedge clk);
        m_score = 0;
        m_sat   = 1'b0;
        verificar("clr score", 16'(placar()), 16'(para_bcd(m_score)));
        verificar("clr sat", 16'(bus.saturou), 16'(m_sat));
        verificar("clr idle", 16'(bus.ocupado), 16'd0);
        verificar("clr ready idle", 16'(bus.pts_ready), 16'd0);
        @(negedge clk);
        verificar("clr no accept", 16'(bus.ocupado), 16'd0);
        bus.limpar    = 1'b0;
        bus.pts_valid = 1'b0;

        // pts_valid held through PASSO: second request only on pts_ready
        esperar_pronto("hold");
        bus.pts_valid = 1'b1;
        bus.pts_val   = 2'd2;
        @(posedge clk);
        @(negedge clk);
        bus.pts_val = 2'd1;
        verificar("hold ready0", 16'(bus.pts_ready), 16'd0);
        @(negedge clk);
        verificar("hold step1", 16'(placar()), 16'h01);
        verificar("hold busy", 16'(bus.ocupado), 16'd1);
        @(negedge clk);
        verificar("hold step2", 16'(placar()), 16'h02);
        verificar("hold idle", 16'(bus.ocupado), 16'd0);
        verificar("hold ready1", 16'(bus.pts_ready), 16'd1);
        @(negedge clk);
        bus.pts_valid = 1'b0;
        verificar("hold 2nd busy", 16'(bus.ocupado), 16'd1);
        @(negedge clk);
        m_score = 3;
        verificar("hold final", 16'(placar()), 16'(para_bcd(m_score)));
        verificar("hold final idle", 16'(bus.ocupado), 16'd0);

        // rst in the middle of PASSO
        esperar_pronto("rstmid");
        bus.pts_valid = 1'b1;
        bus.pts_val   = 2'd3;
        bus.pts_sub   = DIR_SOMA;
        @(posedge clk);
        @(negedge clk);
        bus.pts_valid = 1'b0;
        @(negedge clk);
        verificar("rstmid step1", 16'(placar()), 16'h04);
        rst = 1'b1;
        verificar("rstmid ready", 16'(bus.pts_ready), 16'd0);
        @(negedge clk);
        rst     = 1'b0;
        m_score = 0;
        verificar("rstmid score", 16'(placar()), 16'h00);
        verificar("rstmid busy", 16'(bus.ocupado), 16'd0);
        verificar("rstmid sat", 16'(bus.saturou), 16'd0);

        enviar(1, DIR_SOMA, "after rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/placar_bcd_acumulador.md
Name: placar_bcd_acumulador

Overview:
Per-team score accumulator for the basketball scoreboard. It accepts point events (+1/+2/+3) or corrections (−1/−2/−3) through a valid/ready handshake. It applies them one point per clock to a two-digit BCD score. unidade/dezena drive the n1/n2 digit inputs of the downstream bit-interleaving display packer directly.

Parameters:
LIMITE, 99, saturation score in decimal; legal range 1..99; split into BCD constants LIM_DEZ = LIMITE/10 and LIM_UNI = LIMITE%10 at elaboration.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
pts_valid  input  1  point request present
pts_ready  output  1  block can accept a request this cycle
pts_val  input  2  point magnitude 0..3
pts_sub  input  1  1 = subtract (correction), 0 = add
limpar  input  1  synchronous clear of score and flags, e.g. new game
unidade  output  4  BCD units digit 0..9
dezena  output  4  BCD tens digit 0..9
saturou  output  1  sticky: an add hit LIMITE and points were discarded
ocupado  output  1  high while a request is being applied

Behaviour:
- Reset (rst=1 at edge): unidade=0, dezena=0, saturou=0, ocupado=0, state=OCIOSO, remaining count=0. rst overrides every other input.
- limpar=1 (rst=0): same clear as reset. Aborts any in-progress request; remaining points are lost. Priority is above the handshake.
- pts_ready = (state==OCIOSO) & !limpar & !rst. This is combinational from registered state only, with no path from pts_valid.
- Accept = pts_valid & pts_ready at the edge.
  - pts_val=0: no-op, state stays OCIOSO.
  - pts_val≠0: latch magnitude into a 2-bit counter (resta), latch pts_sub into dir, go to PASSO.
- FSM states: OCIOSO, PASSO.
  - In PASSO, each cycle the score steps ±1 in BCD and resta decrements.
  - When resta reaches 0, the FSM returns to OCIOSO.
  - ocupado = (state==PASSO).
- Latency: a request of N points accepted at edge k yields the final score after edge k+N. pts_ready is high again in the cycle following edge k+N, so the minimum request spacing is N+1 cycles.
- BCD increment: unidade 9→0 with carry into dezena. Decrement: unidade 0→9 with borrow from dezena. Digits never leave 0..9.
- Saturation on add:
  - If the score already equals LIMITE (dezena==LIM_DEZ & unidade==LIM_UNI) at a step, the score holds and saturou←1.
  - resta is forced to 0 and the FSM returns to OCIOSO the same edge.
- Clamp on subtract: at 00 the score holds and remaining steps are discarded, returning to OCIOSO. saturou is unaffected.
- saturou is cleared only by rst or limpar. A later subtract does not clear it.
- Inputs pts_val/pts_sub are ignored while not ready. The requester must hold pts_valid until it sees pts_ready.
- Outputs are registered with no combinational path from inputs, except pts_ready from limpar/rst.

Decomposition:
- Shared package placar_pkg:
  - state enum {OCIOSO, PASSO};
  - BCD_MAX = 4'd9;
  - direction constants DIR_SOMA/DIR_SUB;
  - the default LIMITE = 99.
  The display packer and the other team's accumulator reuse it.
- One natural sub-module: bcd_passo, a combinational one-digit BCD ±1 with carry/borrow in/out. It is instantiated twice (units, tens) with the carry chained.

Test Plan:
- Reset then add: rst 1 cycle; send pts_val=3, pts_sub=0 → ocupado high 3 cycles, score 03, pts_ready back on the 4th cycle after acceptance.
- Carry: preload 08 via +3,+3,+2; then +3 → 11, with units passing 9→0→1 and dezena 0→1 at the correct step.
- Saturation: drive to 98; send +3 → score 99 after 1 step, saturou=1, ocupado drops after 2 cycles total. A further +1 leaves 99 and saturou=1.
- Clamp/borrow: score 10, −2 → 09 then 08. Score 01, −3 → 00, ocupado ends early, saturou unchanged.
- limpar mid-request: score 20, accept +3, assert limpar on the 2nd PASSO cycle → next cycle score 00, saturou 0, OCIOSO. A pts_valid asserted alongside limpar is not accepted.
- Handshake/no-op: hold pts_valid during PASSO → no second acceptance until pts_ready. pts_val=0 accepted → score and ocupado unchanged. rst mid-PASSO → all outputs 0 next cycle.
